laser_path_sequencer: RTL and testbench
=======================================

// Module: laser_path_sequencer
// PURPOSE
//  Frame scheduler for the clap-controlled two-servo laser projector.
//  Generates the 20 ms servo frame tick and walks a 4-step corner table (lado 0-3).
//  Each frame it sets the horizontal/vertical pulse-width targets that the two
//  servo PWM generators latch.
//  Sits between the clap on/off counter (enable) and the servo PWM blocks;
//  owns laser gating and safe parking.
// PARAMETERS
//  FRAME_CYCLES  1_000_000  clk cycles per servo frame (20 ms @ 50 MHz)
//  DWELL_FRAMES  4          frames spent on each lado (4 x 20 ms = 80 ms)
//  PARK_FRAMES   5          frames held at centre after stop before IDLE
//  PW_MIN        50_000     min pulse width, clk cycles (1 ms)
//  PW_MAX        100_000    max pulse width, clk cycles (2 ms)
//  PW_W          17         width of pulse-width outputs
// PORTS
//  clk          in   1     system clock, 50 MHz
//  rst_n        in   1     asynchronous reset, active low
//  enable       in   1     1 = projector ON (from clap counter), level
//  shape_sel    in   2     0 square, 1 horiz line, 2 vert line, 3 centre point
//  frame_start  out  1     1-cycle pulse, first cycle of every frame
//  lado         out  2     current corner index 0..3
//  pw_h         out  PW_W  horizontal servo pulse width (clk cycles)
//  pw_v         out  PW_W  vertical servo pulse width (clk cycles)
//  laser_on     out  1     laser drive
//  busy         out  1     1 in RUN or STOP
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - frame_cnt=0, state=IDLE, lado=0, dwell_cnt=0.
//    - pw_h=pw_v=MID where MID=(PW_MIN+PW_MAX)/2.
//    - laser_on=0, busy=0, frame_start=0.
//  - Frame counter:
//    - frame_cnt runs 0..FRAME_CYCLES-1 and wraps in every state.
//    - frame_start=1 exactly while frame_cnt==0.
//    - Boundary = the edge where frame_cnt wraps to 0. lado, pw_h, pw_v and
//      state change ONLY at a boundary (laser_on excepted), so outputs are
//      constant over a whole frame.
//  - Corner table C(k,shape), values as (h,v):
//    - Square: C0=(MIN,MIN), C1=(MIN,MAX), C2=(MAX,MAX), C3=(MAX,MIN).
//    - Shape 1 (horiz line): h from the square table, v=MID.
//    - Shape 2 (vert line): v from the square table, h=MID.
//    - Shape 3 (centre point): (MID,MID).
//  - FSM states:
//    - IDLE: at a boundary with enable=1, enter RUN. Load lado=0, dwell_cnt=0,
//      latch shape_sel, pw=C0.
//    - RUN: laser_on=1, busy=1. Each boundary increments dwell_cnt.
//      - When dwell_cnt==DWELL_FRAMES-1: dwell_cnt=0, lado=lado+1 (3 wraps to 0),
//        shape_sel re-sampled, pw=C(new lado).
//      - shape_sel changes mid-side are ignored until the next lado step.
//    - enable=0 in RUN: laser_on=0 on the next clk edge (no boundary wait);
//      state goes to STOP.
//    - STOP: busy=1, laser_on=0. At the next boundary pw=(MID,MID) and lado=0;
//      hold PARK_FRAMES boundaries, then IDLE (busy=0).
//      - enable is ignored in STOP; re-enable is honoured from IDLE.
//  - Boundary coinciding with the enable fall: the stop wins, and no lado step
//    occurs.
//  - Arithmetic is unsigned. MID and STEP=(PW_MAX-PW_MIN)/DWELL_FRAMES are
//    localparams; PW_MAX must fit in PW_W bits.
// CONFIGURATION
//  - SWEEP_EN defined: in RUN, pw_h/pw_v ramp from C(lado) toward C(lado+1).
//    - Each boundary moves each axis by STEP toward its target.
//    - The last dwell boundary loads C(lado+1) exactly, so there is no overshoot
//      or rounding residue.
//  - SWEEP_EN undefined: pw jumps corner to corner at lado steps only, and the
//    ramp logic is absent.
// TESTING (bench params: FRAME_CYCLES=20, DWELL_FRAMES=2, PARK_FRAMES=1,
//          PW_MIN=100, PW_MAX=200, PW_W=8; MID=150, STEP=50)
//  1 Reset, enable=0 for 100 cycles -> pw=(150,150), laser_on=0, busy=0;
//    frame_start at cycles 0,20,40,...
//  2 enable=1, shape=0 -> at next boundary laser_on=1, lado=0, pw=(100,100);
//    every 2 frames (100,200),(200,200),(200,100), then wraps to (100,100).
//  3 shape_sel 0->3 mid lado 1 -> lado 1 stays (100,200); lado 2 = (150,150).
//  4 enable 1->0 mid-frame -> laser_on=0 next cycle; next boundary pw=(150,150),
//    lado=0; busy=0 one boundary later; an enable pulse during STOP has no effect.
//  5 rst_n low between clk edges in RUN -> outputs at reset values immediately,
//    frame_cnt=0.
//  6 SWEEP_EN, shape=0 -> pw_v 100,150,200 on successive boundaries across
//    lado 0->1; pw_h constant at 100.

Source files
------------

// File: rtl/laser_path_sequencer.sv
// Servo frame scheduler: emits the frame tick, walks a 4-corner table, gates the laser and parks at centre.
// Optional `SWEEP_EN: pulse widths ramp by STEP per frame toward the next corner instead of jumping.
module laser_path_sequencer #(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int DWELL_FRAMES = 4,
  parameter int PARK_FRAMES  = 5,
  parameter int PW_MIN       = 50_000,
  parameter int PW_MAX       = 100_000,
  parameter int PW_W         = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [1:0]      shape_sel,
  output logic            frame_start,
  output logic [1:0]      lado,
  output logic [PW_W-1:0] pw_h,
  output logic [PW_W-1:0] pw_v,
  output logic            laser_on,
  output logic            busy
);

  localparam int FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int PK_W = (PARK_FRAMES > 0) ? $clog2(PARK_FRAMES + 1) : 1;

  localparam logic [PW_W-1:0] PW_LO   = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0] PW_HI   = PW_W'(PW_MAX);
  localparam logic [PW_W-1:0] PW_MID  = PW_W'((PW_MIN + PW_MAX) / 2);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [PK_W-1:0] PK_DONE = PK_W'(PARK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  // Corner k of the selected shape as {h, v}; lines and point substitute MID on the fixed axes.
  function automatic logic [2*PW_W-1:0] corner(input logic [1:0] k, input logic [1:0] shape);
    logic [PW_W-1:0] sq_h;
    logic [PW_W-1:0] sq_v;
    sq_h = k[1] ? PW_HI : PW_LO;
    sq_v = (k[1] ^ k[0]) ? PW_HI : PW_LO;
    case (shape)
      2'd0:    corner = {sq_h, sq_v};
      2'd1:    corner = {sq_h, PW_MID};
      2'd2:    corner = {PW_MID, sq_v};
      default: corner = {PW_MID, PW_MID};
    endcase
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [FC_W-1:0]   w_frame_cnt_nxt;
  logic              w_boundary;
  logic              r_frame_start;
  logic [1:0]        r_lado;
  logic [1:0]        w_lado_nxt;
  logic [1:0]        w_lado_inc;
  logic [DW_W-1:0]   r_dwell;
  logic [DW_W-1:0]   w_dwell_nxt;
  logic [PK_W-1:0]   r_park;
  logic [PK_W-1:0]   w_park_nxt;
  logic [PW_W-1:0]   r_pw_h;
  logic [PW_W-1:0]   r_pw_v;
  logic [PW_W-1:0]   w_pw_h_nxt;
  logic [PW_W-1:0]   w_pw_v_nxt;
  logic              r_laser;
  logic              w_laser_nxt;
  logic              r_busy;
  logic              w_busy_nxt;

`ifdef SWEEP_EN
  localparam logic [PW_W-1:0] PW_STEP = PW_W'((PW_MAX - PW_MIN) / DWELL_FRAMES);

  logic [1:0]        r_shape;
  logic [1:0]        w_shape_nxt;
  logic [PW_W-1:0]   w_tgt_h;
  logic [PW_W-1:0]   w_tgt_v;

  // Move one STEP toward the target, clamping so the ramp never overshoots.
  function automatic logic [PW_W-1:0] ramp(input logic [PW_W-1:0] cur, input logic [PW_W-1:0] tgt);
    if (cur < tgt) begin
      ramp = ((tgt - cur) > PW_STEP) ? (cur + PW_STEP) : tgt;
    end else if (cur > tgt) begin
      ramp = ((cur - tgt) > PW_STEP) ? (cur - PW_STEP) : tgt;
    end else begin
      ramp = cur;
    end
  endfunction

  assign {w_tgt_h, w_tgt_v} = corner(w_lado_inc, r_shape);

  // Shape latched at each lado step so the ramp target stays fixed across the side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shape <= 2'd0;
    end else begin
      r_shape <= w_shape_nxt;
    end
  end
`endif

  // Frame counter wrap; the wrap edge is the only point where table state advances.
  always_comb begin
    w_boundary      = (r_frame_cnt == FC_LAST);
    w_frame_cnt_nxt = w_boundary ? {FC_W{1'b0}} : (r_frame_cnt + FC_W'(1));
    w_lado_inc      = r_lado + 2'd1;
  end

  // Next-state and output decode; the enable fall is handled ahead of any boundary work.
  always_comb begin
    w_state_nxt = r_state;
    w_lado_nxt  = r_lado;
    w_dwell_nxt = r_dwell;
    w_park_nxt  = r_park;
    w_pw_h_nxt  = r_pw_h;
    w_pw_v_nxt  = r_pw_v;
    w_laser_nxt = 1'b0;
`ifdef SWEEP_EN
    w_shape_nxt = r_shape;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_boundary && enable) begin
          w_state_nxt = S_RUN;
          w_lado_nxt  = 2'd0;
          w_dwell_nxt = {DW_W{1'b0}};
          {w_pw_h_nxt, w_pw_v_nxt} = corner(2'd0, shape_sel);
          w_laser_nxt = 1'b1;
`ifdef SWEEP_EN
          w_shape_nxt = shape_sel;
`endif
        end else begin
          w_laser_nxt = 1'b0;
        end
      end
      S_RUN: begin
        w_laser_nxt = 1'b1;
        if (!enable) begin
          w_state_nxt = S_STOP;
          w_laser_nxt = 1'b0;
          w_park_nxt  = {PK_W{1'b0}};
        end else if (w_boundary) begin
          if (r_dwell == DW_LAST) begin
            w_dwell_nxt = {DW_W{1'b0}};
            w_lado_nxt  = w_lado_inc;
            {w_pw_h_nxt, w_pw_v_nxt} = corner(w_lado_inc, shape_sel);
`ifdef SWEEP_EN
            w_shape_nxt = shape_sel;
`endif
          end else begin
            w_dwell_nxt = r_dwell + DW_W'(1);
`ifdef SWEEP_EN
            w_pw_h_nxt  = ramp(r_pw_h, w_tgt_h);
            w_pw_v_nxt  = ramp(r_pw_v, w_tgt_v);
`else
            w_pw_h_nxt  = r_pw_h;
            w_pw_v_nxt  = r_pw_v;
`endif
          end
        end else begin
          w_dwell_nxt = r_dwell;
        end
      end
      S_STOP: begin
        if (w_boundary) begin
          if (r_park == PK_DONE) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_park_nxt  = r_park + PK_W'(1);
            w_lado_nxt  = 2'd0;
            w_pw_h_nxt  = PW_MID;
            w_pw_v_nxt  = PW_MID;
          end
        end else begin
          w_park_nxt = r_park;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Every output is taken from a flop so the servo blocks see a frame-stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= {FC_W{1'b0}};
      r_frame_start <= 1'b0;
      r_lado        <= 2'd0;
      r_dwell       <= {DW_W{1'b0}};
      r_park        <= {PK_W{1'b0}};
      r_pw_h        <= PW_MID;
      r_pw_v        <= PW_MID;
      r_laser       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_frame_start <= w_boundary;
      r_lado        <= w_lado_nxt;
      r_dwell       <= w_dwell_nxt;
      r_park        <= w_park_nxt;
      r_pw_h        <= w_pw_h_nxt;
      r_pw_v        <= w_pw_v_nxt;
      r_laser       <= w_laser_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign frame_start = r_frame_start;
  assign lado        = r_lado;
  assign pw_h        = r_pw_h;
  assign pw_v        = r_pw_v;
  assign laser_on    = r_laser;
  assign busy        = r_busy;

endmodule

// File: tb/tb_laser_path_sequencer.sv
// Directed bench for laser_path_sequencer with small frame/pulse parameters; handles SWEEP_EN builds too.
module tb_laser_path_sequencer;

  localparam int FC = 20;
`ifdef SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] shape_sel;
  logic       frame_start;
  logic [1:0] lado;
  logic [7:0] pw_h;
  logic [7:0] pw_v;
  logic       laser_on;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic       en;
    logic [1:0] shape;
    int         lado;
    int         h;
    int         v;
    int         sh;
    int         sv;
  } vec_t;

  vec_t vecs[17];

  laser_path_sequencer #(
    .FRAME_CYCLES(20),
    .DWELL_FRAMES(2),
    .PARK_FRAMES(1),
    .PW_MIN(100),
    .PW_MAX(200),
    .PW_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .shape_sel(shape_sel),
    .frame_start(frame_start),
    .lado(lado),
    .pw_h(pw_h),
    .pw_v(pw_v),
    .laser_on(laser_on),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [1:0] shape, input int l,
                              input int h, input int v, input int sh, input int sv);
    vec_t r;
    r.en = en; r.shape = shape; r.lado = l; r.h = h; r.v = v; r.sh = sh; r.sv = sv;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input int l, input int h, input int v,
                     input int las, input int bsy);
    check({tag, ".lado"},     {30'd0, lado},       l);
    check({tag, ".pw_h"},     {24'd0, pw_h},       h);
    check({tag, ".pw_v"},     {24'd0, pw_v},       v);
    check({tag, ".laser_on"}, {31'd0, laser_on},   las);
    check({tag, ".busy"},     {31'd0, busy},       bsy);
  endtask

  // One clock: active edge, then settle to the falling edge where sampling and driving happen.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic to_boundary();
    step(FC - (cyc % FC));
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 2'd0, 0, 100, 100, 100, 100);
    vecs[1]  = mk(1'b1, 2'd0, 0, 100, 100, 100, 150);
    vecs[2]  = mk(1'b1, 2'd0, 1, 100, 200, 100, 200);
    vecs[3]  = mk(1'b1, 2'd3, 1, 100, 200, 150, 200);
    vecs[4]  = mk(1'b1, 2'd3, 2, 150, 150, 150, 150);
    vecs[5]  = mk(1'b1, 2'd0, 2, 150, 150, 150, 150);
    vecs[6]  = mk(1'b1, 2'd0, 3, 200, 100, 200, 100);
    vecs[7]  = mk(1'b1, 2'd0, 3, 200, 100, 150, 100);
    vecs[8]  = mk(1'b1, 2'd0, 0, 100, 100, 100, 100);
    vecs[9]  = mk(1'b1, 2'd0, 0, 100, 100, 100, 150);
    vecs[10] = mk(1'b1, 2'd0, 1, 100, 200, 100, 200);
    vecs[11] = mk(1'b1, 2'd0, 1, 100, 200, 150, 200);
    vecs[12] = mk(1'b1, 2'd0, 2, 200, 200, 200, 200);
    vecs[13] = mk(1'b1, 2'd1, 2, 200, 200, 200, 150);
    vecs[14] = mk(1'b1, 2'd1, 3, 200, 150, 200, 150);
    vecs[15] = mk(1'b1, 2'd2, 3, 200, 150, 150, 150);
    vecs[16] = mk(1'b1, 2'd2, 0, 150, 100, 150, 100);

    rst_n = 1'b0;
    enable = 1'b0;
    shape_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset", 0, 150, 150, 0, 0);
    check("reset.frame_start", {31'd0, frame_start}, 0);
    rst_n = 1'b1;
    cyc = 0;

    // Idle: frame tick every FC cycles, outputs parked
    for (int i = 1; i <= 100; i++) begin
      step(1);
      check($sformatf("idle.fs@%0d", i), {31'd0, frame_start}, (i % FC == 0) ? 1 : 0);
    end
    chk("idle", 0, 150, 150, 0, 0);

    // Table: inputs set mid-frame, outputs checked right after the following boundary
    for (int k = 0; k < 17; k++) begin
      step(10);
      enable = vecs[k].en;
      shape_sel = vecs[k].shape;
      to_boundary();
      chk($sformatf("vec%0d", k), vecs[k].lado,
          SWEEP ? vecs[k].sh : vecs[k].h, SWEEP ? vecs[k].sv : vecs[k].v, 1, 1);
      check($sformatf("vec%0d.frame_start", k), {31'd0, frame_start}, 1);
    end

    // Mid-frame stop: laser drops next edge, park at boundary, idle one boundary later
    step(5);
    enable = 1'b0;
    step(1);
    chk("stop_next", 0, 150, 100, 0, 1);
    step(3);
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    to_boundary();
    chk("park", 0, 150, 150, 0, 1);
    to_boundary();
    chk("park_idle", 0, 150, 150, 0, 0);
    to_boundary();
    chk("idle_after_pulse", 0, 150, 150, 0, 0);

    // Enable fall on the very edge that would step lado: stop wins
    step(10);
    enable = 1'b1;
    shape_sel = 2'd0;
    to_boundary();
    chk("reenter", 0, 100, 100, 1, 1);
    step(10);
    to_boundary();
    chk("dwell1", 0, 100, SWEEP ? 150 : 100, 1, 1);
    step(FC - 1);
    enable = 1'b0;
    step(1);
    chk("coincide", 0, 100, SWEEP ? 150 : 100, 0, 1);
    check("coincide.frame_start", {31'd0, frame_start}, 1);
    to_boundary();
    chk("coincide_park", 0, 150, 150, 0, 1);
    to_boundary();
    chk("coincide_idle", 0, 150, 150, 0, 0);

    // Asynchronous reset between edges while running
    step(10);
    enable = 1'b1;
    to_boundary();
    chk("run_again", 0, 100, 100, 1, 1);
    step(7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 0, 150, 150, 0, 0);
    check("async_rst.frame_start", {31'd0, frame_start}, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    step(FC - 1);
    check("rst_fs19", {31'd0, frame_start}, 0);
    step(1);
    check("rst_fs20", {31'd0, frame_start}, 1);
    chk("rst_idle", 0, 150, 150, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
